// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared state encoding, opcode/func constants, fault codes and
//               opcode class type for the multi-cycle sequencer and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_halt   = 3'd6;

    localparam logic [5:0] c_op_rtype  = 6'h00;
    localparam logic [5:0] c_op_regimm = 6'h01;
    localparam logic [5:0] c_op_j      = 6'h02;
    localparam logic [5:0] c_op_jal    = 6'h03;
    localparam logic [5:0] c_op_beq    = 6'h04;
    localparam logic [5:0] c_op_bne    = 6'h05;
    localparam logic [5:0] c_op_blez   = 6'h06;
    localparam logic [5:0] c_op_bgtz   = 6'h07;
    localparam logic [5:0] c_op_addi   = 6'h08;
    localparam logic [5:0] c_op_addiu  = 6'h09;
    localparam logic [5:0] c_op_slti   = 6'h0A;
    localparam logic [5:0] c_op_andi   = 6'h0C;
    localparam logic [5:0] c_op_ori    = 6'h0D;
    localparam logic [5:0] c_op_xori   = 6'h0E;
    localparam logic [5:0] c_op_lui    = 6'h0F;
    localparam logic [5:0] c_op_lb     = 6'h20;
    localparam logic [5:0] c_op_lw     = 6'h23;
    localparam logic [5:0] c_op_sb     = 6'h28;
    localparam logic [5:0] c_op_sw     = 6'h2B;

    localparam logic [5:0] c_func_syscall = 6'h0C;

    localparam logic [1:0] c_fault_none    = 2'd0;
    localparam logic [1:0] c_fault_syscall = 2'd1;
    localparam logic [1:0] c_fault_illegal = 2'd2;
    localparam logic [1:0] c_fault_timeout = 2'd3;

    localparam logic [1:0] c_pc_plus4  = 2'd0;
    localparam logic [1:0] c_pc_branch = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } op_class_e;

endpackage
`default_nettype wire

// File: rtl/mc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer_if
// Description : Instruction/flag inputs and control strobes of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_sequencer_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       halted;
    logic [1:0] fault;

    modport master (
        input  opcode, func, alu_zero, mem_ready,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               reg_write, halted, fault
    );

    modport slave (
        output opcode, func, alu_zero, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               reg_write, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/mc_sequencer_op_classify.sv
`default_nettype none
// ============================================================================
// Module      : op_classify
// Description : Combinational opcode class lookup plus syscall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module op_classify
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output op_class_e  o_class,
    output logic       o_syscall
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            c_op_rtype, c_op_addi, c_op_addiu, c_op_slti,
            c_op_andi, c_op_ori, c_op_xori, c_op_lui:     o_class = CLS_ALU;
            // regimm/blez/bgtz need more than alu_zero; they resolve as branches
            c_op_regimm, c_op_beq, c_op_bne,
            c_op_blez, c_op_bgtz:                         o_class = CLS_BRANCH;
            c_op_j, c_op_jal:                             o_class = CLS_JUMP;
            c_op_lb, c_op_lw:                             o_class = CLS_LOAD;
            c_op_sb, c_op_sw:                             o_class = CLS_STORE;
            default:                                      o_class = CLS_ILLEGAL;
        endcase
    end

    assign o_syscall = (i_opcode == c_op_rtype) && (i_func == c_func_syscall);

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle MIPS control sequencer with bus-timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mc_sequencer_if.master bus
);
    import mips_pkg::*;

    localparam logic [3:0] c_wait_last = 4'(TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [1:0] r_fault;
    logic [1:0] w_fault_next;
    logic [3:0] r_wait;

    op_class_e  w_class;
    logic       w_syscall;
    logic       w_wait_expired;
    logic       w_branch_taken;
    logic       w_entering_access;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_addr_sel;
    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_reg_write;

    op_classify u_op_classify (
        .i_opcode  (bus.opcode),
        .i_func    (bus.func),
        .o_class   (w_class),
        .o_syscall (w_syscall)
    );

    assign w_wait_expired = (r_wait == c_wait_last);
    assign w_branch_taken = ((bus.opcode == c_op_beq) &&  bus.alu_zero) ||
                            ((bus.opcode == c_op_bne) && !bus.alu_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_fault <= c_fault_none;
        end else begin
            r_state <= w_state_next;
            r_fault <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        case (r_state)
            c_st_idle:   w_state_next = c_st_fetch;
            c_st_fetch: begin
                // a completing access wins over an expiring watchdog
                if (bus.mem_ready) begin
                    w_state_next = c_st_decode;
                end else if (w_wait_expired) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_timeout;
                end
            end
            c_st_decode: begin
                if (w_syscall) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_syscall;
                end else begin
                    case (w_class)
                        CLS_ILLEGAL: begin
                            w_state_next = c_st_halt;
                            w_fault_next = c_fault_illegal;
                        end
                        CLS_JUMP: w_state_next = c_st_fetch;
                        default:  w_state_next = c_st_exec;
                    endcase
                end
            end
            c_st_exec: begin
                case (w_class)
                    CLS_BRANCH:           w_state_next = c_st_fetch;
                    CLS_LOAD, CLS_STORE:  w_state_next = c_st_mem;
                    default:              w_state_next = c_st_wb;
                endcase
            end
            c_st_mem: begin
                if (bus.mem_ready) begin
                    w_state_next = (w_class == CLS_STORE) ? c_st_fetch : c_st_wb;
                end else if (w_wait_expired) begin
                    w_state_next = c_st_halt;
                    w_fault_next = c_fault_timeout;
                end
            end
            c_st_wb:     w_state_next = c_st_fetch;
            c_st_halt:   w_state_next = c_st_halt;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_addr_sel  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = c_pc_plus4;
        w_reg_write = 1'b0;
        // outputs are forced quiet for the whole reset window
        if (!rst) begin
            case (r_state)
                c_st_fetch: begin
                    w_mem_req  = 1'b1;
                    w_ir_write = bus.mem_ready;
                    w_pc_write = bus.mem_ready;
                end
                c_st_decode: begin
                    if (!w_syscall && (w_class == CLS_JUMP)) begin
                        w_pc_write  = 1'b1;
                        w_pc_src    = c_pc_jump;
                        w_reg_write = (bus.opcode == c_op_jal);
                    end
                end
                c_st_exec: begin
                    if ((w_class == CLS_BRANCH) && w_branch_taken) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = c_pc_branch;
                    end
                end
                c_st_mem: begin
                    w_mem_req  = 1'b1;
                    w_addr_sel = 1'b1;
                    w_mem_we   = (w_class == CLS_STORE);
                end
                c_st_wb:  w_reg_write = 1'b1;
                default:  ;
            endcase
        end
    end

    assign w_entering_access = (w_state_next != r_state) &&
                               ((w_state_next == c_st_fetch) || (w_state_next == c_st_mem));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 4'd0;
        end else if (w_entering_access) begin
            r_wait <= 4'd0;
        end else if (w_mem_req && !bus.mem_ready) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.addr_sel  = w_addr_sel;
    assign bus.ir_write  = w_ir_write;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.reg_write = w_reg_write;
    assign bus.halted    = (r_state == c_st_halt) && !rst;
    assign bus.fault     = rst ? c_fault_none : r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_sequencer
// Description : Randomized self-checking bench; per-instruction cycle traces
//               are built from instruction semantics and compared each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

    localparam int TO = 15;

    localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LD = 3, K_ST = 4, K_ILL = 5, K_SYS = 6;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        az;
        logic        rdy;
        logic [10:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t q[$];

    mc_sequencer_if bus();

    mc_sequencer #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, halted, fault}
    function automatic logic [10:0] ev(input logic mreq, input logic we, input logic asel,
                                       input logic irw, input logic pcw, input logic [1:0] src,
                                       input logic rw, input logic hlt, input logic [1:0] flt);
        return {mreq, we, asel, irw, pcw, src, rw, hlt, flt};
    endfunction

    function automatic logic [10:0] observed();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.reg_write, bus.halted, bus.fault};
    endfunction

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                            return (fn == 6'h0C) ? K_SYS : K_ALU;
            6'h08, 6'h09, 6'h0A, 6'h0C,
            6'h0D, 6'h0E, 6'h0F:              return K_ALU;
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return K_BR;
            6'h02, 6'h03:                     return K_JMP;
            6'h20, 6'h23:                     return K_LD;
            6'h28, 6'h2B:                     return K_ST;
            default:                          return K_ILL;
        endcase
    endfunction

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic az,
                        input logic rdy, input logic [10:0] exp);
        cyc_t c;
        c.op = op; c.fn = fn; c.az = az; c.rdy = rdy; c.exp = exp;
        q.push_back(c);
    endtask

    // fw/mw: cycles the memory withholds mem_ready; >= TO means it never answers
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                             input int fw, input int mw, output logic [1:0] flt);
        int   k;
        logic taken;
        logic st;
        k   = kind(op, fn);
        flt = 2'd0;
        for (int i = 0; i < fw && i < TO; i++) push(op, fn, az, 1'b0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        if (fw >= TO) begin
            flt = 2'd3;
            return;
        end
        push(op, fn, az, 1'b1, ev(1, 0, 0, 1, 1, 2'd0, 0, 0, 0));
        if (k == K_SYS || k == K_ILL) begin
            push(op, fn, az, noise(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
            flt = (k == K_SYS) ? 2'd1 : 2'd2;
            return;
        end
        if (k == K_JMP) begin
            push(op, fn, az, noise(), ev(0, 0, 0, 0, 1, 2'd2, (op == 6'h03), 0, 0));
            return;
        end
        push(op, fn, az, noise(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_BR) begin
            taken = ((op == 6'h04) && az) || ((op == 6'h05) && !az);
            push(op, fn, az, noise(), ev(0, 0, 0, 0, taken, taken ? 2'd1 : 2'd0, 0, 0, 0));
            return;
        end
        push(op, fn, az, noise(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_LD || k == K_ST) begin
            st = (k == K_ST);
            for (int i = 0; i < mw && i < TO; i++) push(op, fn, az, 1'b0, ev(1, st, 1, 0, 0, 0, 0, 0, 0));
            if (mw >= TO) begin
                flt = 2'd3;
                return;
            end
            push(op, fn, az, 1'b1, ev(1, st, 1, 0, 0, 0, 0, 0, 0));
            if (st) return;
        end
        push(op, fn, az, noise(), ev(0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic add_halt(input logic [1:0] flt, input int n);
        for (int i = 0; i < n; i++)
            push(6'($urandom), 6'($urandom), noise(), noise(), ev(0, 0, 0, 0, 0, 0, 0, 1, flt));
    endtask

    task automatic run_queue();
        cyc_t        c;
        logic [10:0] obs;
        logic [10:0] exp;
        int          idx;
        idx = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            bus.opcode    = c.op;
            bus.func      = c.fn;
            bus.alu_zero  = c.az;
            bus.mem_ready = c.rdy;
            @(negedge clk);
            obs = observed();
            exp = c.exp;
            // mem_we/addr_sel only carry meaning during an access
            if (!exp[10]) begin
                obs[9:8] = 2'b00;
                exp[9:8] = 2'b00;
            end
            check_eq($sformatf("trace_op%02h_c%0d", c.op, idx), 32'(obs), 32'(exp));
            idx++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.mem_ready = noise();
        @(negedge clk);
        check_eq("rst_hold", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_idle", 32'(observed()), 32'd0);
    endtask

    logic [5:0] pool [24] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                              6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28,
                              6'h2B, 6'h04, 6'h23, 6'h2B, 6'h0B, 6'h10, 6'h3F, 6'h31};

    initial begin
        logic [1:0] flt;
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;

        bus.opcode = 6'h00; bus.func = 6'h20; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
        do_reset();

        // addi, beq taken/not taken, sw with delayed ready, lw, j, jal, bne
        add_instr(6'h08, 6'h05, 1'b0, 2, 0, flt);
        add_instr(6'h04, 6'h00, 1'b1, 0, 0, flt);
        add_instr(6'h04, 6'h00, 1'b0, 1, 0, flt);
        add_instr(6'h2B, 6'h00, 1'b0, 0, 3, flt);
        add_instr(6'h23, 6'h00, 1'b0, 1, 2, flt);
        add_instr(6'h02, 6'h00, 1'b0, 0, 0, flt);
        add_instr(6'h03, 6'h00, 1'b0, 0, 0, flt);
        add_instr(6'h05, 6'h00, 1'b0, 0, 0, flt);
        add_instr(6'h05, 6'h00, 1'b1, 0, 0, flt);
        // ready arriving on the last permitted cycle, in fetch and in mem
        add_instr(6'h0D, 6'h00, 1'b0, TO - 1, 0, flt);
        add_instr(6'h20, 6'h00, 1'b0, 0, TO - 1, flt);
        run_queue();

        add_instr(6'h08, 6'h00, 1'b0, TO, 0, flt);
        add_halt(flt, 4);
        run_queue();
        do_reset();

        add_instr(6'h28, 6'h00, 1'b0, 0, TO, flt);
        add_halt(flt, 3);
        run_queue();
        do_reset();

        add_instr(6'h3F, 6'h00, 1'b0, 0, 0, flt);
        add_halt(flt, 5);
        run_queue();
        do_reset();

        add_instr(6'h00, 6'h0C, 1'b0, 1, 0, flt);
        add_halt(flt, 5);
        run_queue();
        do_reset();

        // reset landing in the middle of a store's memory wait
        push(6'h2B, 6'h00, 1'b0, 1'b1, ev(1, 0, 0, 1, 1, 0, 0, 0, 0));
        push(6'h2B, 6'h00, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(6'h2B, 6'h00, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) push(6'h2B, 6'h00, 1'b0, 1'b0, ev(1, 1, 1, 0, 0, 0, 0, 0, 0));
        run_queue();
        do_reset();
        add_instr(6'h08, 6'h00, 1'b0, 1, 0, flt);
        run_queue();

        for (int n = 0; n < 120; n++) begin
            op = pool[$urandom_range(0, 23)];
            fn = ($urandom_range(0, 7) == 0) ? 6'h0C : 6'($urandom);
            fw = ($urandom_range(0, 30) == 0) ? TO : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 30) == 0) ? TO : int'($urandom_range(0, 4));
            if ($urandom_range(0, 10) == 0) fw = TO - 1;
            add_instr(op, fn, 1'($urandom_range(0, 1)), fw, mw, flt);
            if (flt != 2'd0) begin
                add_halt(flt, int'($urandom_range(1, 4)));
                run_queue();
                do_reset();
            end else begin
                run_queue();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
